// File: rtl/psychic5_vram_arb_pkg.sv
// Shared types and defaults for the Psychic 5 VRAM time-slot arbiter.
// Optional posted-write buffer: define PSYCHIC5_VRAM_ARB_WRBUF_EN.
package psychic5_vram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SLOT = 2'd1,
    ST_ACCESS    = 2'd2,
    ST_HOLD      = 2'd3
  } arb_state_t;

  localparam logic [7:0] SLOT_MASK_DEF = 8'b1100_0000;
  localparam int         AW_DEF        = 13;

  function automatic logic phase_is_slot(
    input logic [7:0] mask,
    input logic [2:0] ph
  );
    return mask[ph];
  endfunction

endpackage

// File: rtl/psychic5_vram_wrbuf.sv
// One-entry posted-write buffer for the VRAM arbiter.
// A load in the same cycle as a drain keeps the buffer full with new data.
module psychic5_vram_wrbuf
  import psychic5_vram_arb_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          drain,
  input  logic [AW-1:0] addr_in,
  input  logic [7:0]    data_in,
  output logic          full,
  output logic [AW-1:0] addr,
  output logic [7:0]    data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      addr <= addr_in;
      data <= data_in;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/psychic5_vram_arbiter.sv
// Time-slot arbiter sharing one VRAM port between video fetch and CPU.
// Define PSYCHIC5_VRAM_ARB_WRBUF_EN to post CPU writes into a buffer.
module psychic5_vram_arbiter
  import psychic5_vram_arb_pkg::*;
#(
  parameter logic [7:0] CPU_SLOT_MASK = SLOT_MASK_DEF,
  parameter int         AW            = AW_DEF
) (
  input  logic          i_EMU_MCLK,
  input  logic          i_EMU_MRST_n,
  input  logic          i_EMU_CLK6MPCEN_n,
  input  logic          i_ABS_4H,
  input  logic          i_ABS_2H,
  input  logic          i_ABS_1H,
  input  logic [AW-1:0] i_CPU_ADDR,
  input  logic [7:0]    i_CPU_DATA_WR,
  input  logic          i_CPU_CS_n,
  input  logic          i_CPU_RD_n,
  input  logic          i_CPU_WR_n,
  output logic          o_CPU_WAIT_n,
  output logic [7:0]    o_CPU_DATA_RD,
  input  logic [AW-1:0] i_VID_ADDR,
  output logic [7:0]    o_VID_DATA,
  output logic [AW-1:0] o_RAM_ADDR,
  output logic [7:0]    o_RAM_DI,
  output logic          o_RAM_WE,
  input  logic [7:0]    i_RAM_DO
);

  arb_state_t state, state_n;

  logic          tick;
  logic          slot;
  logic          req;
  logic          req_q;
  logic          wr_q;
  logic          cpu_go;
  logic          cap_rd;
  logic          drain;
  logic          can_post;
  logic          last_cpu;
  logic [AW-1:0] mux_addr;
  logic [7:0]    mux_di;
  logic          mux_we;

  assign tick = !i_EMU_CLK6MPCEN_n;
  assign slot = phase_is_slot(CPU_SLOT_MASK,
                              {i_ABS_4H, i_ABS_2H, i_ABS_1H});
  assign req  = !i_CPU_CS_n && (!i_CPU_RD_n || !i_CPU_WR_n);

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_MRST_n) begin
    if (!i_EMU_MRST_n) begin
      req_q <= 1'b0;
      wr_q  <= 1'b0;
    end else begin
      req_q <= req;
      wr_q  <= !i_CPU_WR_n && i_CPU_RD_n;
    end
  end

`ifdef PSYCHIC5_VRAM_ARB_WRBUF_EN
  logic          full;
  logic          load;
  logic [AW-1:0] buf_addr;
  logic [7:0]    buf_data;

  // A pending write drains in the first CPU slot, ahead of any CPU read.
  assign drain    = full && tick && slot;
  assign can_post = wr_q && (!full || drain);
  assign load     = req_q && can_post &&
                    (state == ST_IDLE || state == ST_WAIT_SLOT);

  psychic5_vram_wrbuf #(
    .AW(AW)
  ) u_wrbuf (
    .clk    (i_EMU_MCLK),
    .rst_n  (i_EMU_MRST_n),
    .load   (load),
    .drain  (drain),
    .addr_in(i_CPU_ADDR),
    .data_in(i_CPU_DATA_WR),
    .full   (full),
    .addr   (buf_addr),
    .data   (buf_data)
  );
`else
  assign drain    = 1'b0;
  assign can_post = 1'b0;
`endif

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_MRST_n) begin
    if (!i_EMU_MRST_n) state <= ST_IDLE;
    else               state <= state_n;
  end

  always_comb begin
    state_n = state;
    cpu_go  = 1'b0;
    cap_rd  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req_q) state_n = can_post ? ST_HOLD : ST_WAIT_SLOT;
      end
      ST_WAIT_SLOT: begin
        if (!req_q) begin
          state_n = ST_IDLE;
        end else if (can_post) begin
          state_n = ST_HOLD;
        end else if (tick && slot && !drain) begin
          cpu_go  = 1'b1;
          state_n = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!req_q) begin
          state_n = ST_IDLE;
        end else if (tick) begin
          cap_rd  = 1'b1;
          state_n = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!req_q) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign o_CPU_WAIT_n = !(req_q && state != ST_HOLD &&
                          !(state == ST_IDLE && can_post));

  always_comb begin
    mux_addr = i_VID_ADDR;
    mux_di   = o_RAM_DI;
    mux_we   = 1'b0;
    unique case (1'b1)
`ifdef PSYCHIC5_VRAM_ARB_WRBUF_EN
      drain: begin
        mux_addr = buf_addr;
        mux_di   = buf_data;
        mux_we   = 1'b1;
      end
`endif
      cpu_go: begin
        mux_addr = i_CPU_ADDR;
        mux_di   = i_CPU_DATA_WR;
        mux_we   = wr_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_MRST_n) begin
    if (!i_EMU_MRST_n) begin
      o_RAM_ADDR <= '0;
      o_RAM_DI   <= '0;
      o_RAM_WE   <= 1'b0;
    end else if (tick) begin
      o_RAM_ADDR <= mux_addr;
      o_RAM_DI   <= mux_di;
      o_RAM_WE   <= mux_we;
    end else if (state == ST_ACCESS && !req_q) begin
      // CPU gave up mid-access: withdraw the write strobe early.
      o_RAM_WE   <= 1'b0;
    end
  end

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_MRST_n) begin
    if (!i_EMU_MRST_n) begin
      last_cpu      <= 1'b0;
      o_VID_DATA    <= '0;
      o_CPU_DATA_RD <= '0;
    end else begin
      if (tick) begin
        last_cpu <= cpu_go || drain;
        if (!last_cpu) o_VID_DATA <= i_RAM_DO;
      end
      if (cap_rd && !wr_q) o_CPU_DATA_RD <= i_RAM_DO;
    end
  end

endmodule

// File: tb/tb_psychic5_vram_arbiter.sv
// Directed bench for psychic5_vram_arbiter with a behavioural VRAM.
// Covers PSYCHIC5_VRAM_ARB_WRBUF_EN builds as well as the default.
module tb_psychic5_vram_arbiter;

  typedef struct {
    logic        rd;
    logic [12:0] addr;
    logic [7:0]  data;
  } acc_t;

  typedef struct {
    logic [2:0] ph;
    logic [7:0] exp;
  } vid_t;

  logic        clk;
  logic        rst_n;
  logic        clk6_n;
  logic [2:0]  phase;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cs_n, rd_n, wr_n;
  logic        wait_n;
  logic [7:0]  cpu_rdata;
  logic [12:0] vid_addr;
  logic [7:0]  vid_data;
  logic [12:0] ram_addr;
  logic [7:0]  ram_di;
  logic        ram_we;
  logic [7:0]  ram_do;
  logic [7:0]  mem [0:8191];

  int total = 0;
  int bad   = 0;
  int we_cyc = 0;
  int div;

  acc_t acc_tab [8];
  vid_t vid_tab [8];

  assign vid_addr = {10'h200, phase};

  psychic5_vram_arbiter dut (
    .i_EMU_MCLK       (clk),
    .i_EMU_MRST_n     (rst_n),
    .i_EMU_CLK6MPCEN_n(clk6_n),
    .i_ABS_4H         (phase[2]),
    .i_ABS_2H         (phase[1]),
    .i_ABS_1H         (phase[0]),
    .i_CPU_ADDR       (cpu_addr),
    .i_CPU_DATA_WR    (cpu_wdata),
    .i_CPU_CS_n       (cs_n),
    .i_CPU_RD_n       (rd_n),
    .i_CPU_WR_n       (wr_n),
    .o_CPU_WAIT_n     (wait_n),
    .o_CPU_DATA_RD    (cpu_rdata),
    .i_VID_ADDR       (vid_addr),
    .o_VID_DATA       (vid_data),
    .o_RAM_ADDR       (ram_addr),
    .o_RAM_DI         (ram_di),
    .o_RAM_WE         (ram_we),
    .i_RAM_DO         (ram_do)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pixel tick every 4 MCLK; phase advances right after each tick.
  initial begin
    clk6_n = 1'b1;
    phase  = 3'd0;
    div    = 0;
    forever begin
      @(negedge clk);
      div    = (div + 1) % 4;
      clk6_n = (div != 3);
      if (div == 0) phase = phase + 3'd1;
    end
  end

  initial begin
    ram_do = 8'h00;
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    mem[13'h0123] = 8'h5A;
    for (int k = 0; k < 8; k++) mem[13'h1000 + k] = 8'hC0 + 8'(k);
    forever begin
      @(posedge clk);
      ram_do <= mem[ram_addr];
      if (ram_we) mem[ram_addr] = ram_di;
    end
  end

  always @(posedge clk) if (ram_we) we_cyc++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick_wait(input logic [2:0] p);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clk);
      if (!clk6_n && phase == p) hit = 1'b1;
    end
    #1;
    if (!hit) chk("tick_timeout", 0, 1);
  endtask

  task automatic drive(input logic is_rd, input logic [12:0] a,
                       input logic [7:0] d);
    cpu_addr  = a;
    cpu_wdata = d;
    cs_n      = 1'b0;
    rd_n      = !is_rd;
    wr_n      = is_rd;
  endtask

  task automatic release_bus();
    cs_n = 1'b1;
    rd_n = 1'b1;
    wr_n = 1'b1;
  endtask

  task automatic cpu_access(input logic is_rd, input logic [12:0] a,
                            input logic [7:0] d, output logic [7:0] q,
                            output bit ok);
    @(negedge clk);
    drive(is_rd, a, d);
    repeat (3) @(negedge clk);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (wait_n) ok = 1'b1;
      else @(negedge clk);
    end
    q = cpu_rdata;
    release_bus();
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"},     ram_we,    0);
    chk({tag, "_addr"},   ram_addr,  0);
    chk({tag, "_di"},     ram_di,    0);
    chk({tag, "_wait_n"}, wait_n,    1);
    chk({tag, "_rdata"},  cpu_rdata, 0);
    chk({tag, "_vid"},    vid_data,  0);
  endtask

  logic [7:0] q;
  bit         ok;
  int         we0;
  logic [7:0] exp_rd;

  initial begin
    rst_n = 1'b0;
    release_bus();
    cpu_addr  = '0;
    cpu_wdata = '0;

    acc_tab[0] = '{1'b1, 13'h0123, 8'h5A};
    acc_tab[1] = '{1'b0, 13'h1FFF, 8'h3C};
    acc_tab[2] = '{1'b1, 13'h1FFF, 8'h3C};
    acc_tab[3] = '{1'b0, 13'h0040, 8'hA5};
    acc_tab[4] = '{1'b1, 13'h0040, 8'hA5};
    acc_tab[5] = '{1'b0, 13'h0000, 8'h99};
    acc_tab[6] = '{1'b1, 13'h0000, 8'h99};
    acc_tab[7] = '{1'b1, 13'h0001, 8'h00};
    for (int k = 0; k < 8; k++)
      vid_tab[k] = '{3'(k + 1), 8'hC0 + 8'(k)};

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // read 0x0123 raised just after the phase-0 tick
    tick_wait(3'd0);
    @(negedge clk);
    we0 = we_cyc;
    drive(1'b1, 13'h0123, 8'h00);
    tick_wait(3'd5);
    chk("rd_wait_ph5", wait_n, 0);
    chk("rd_addr_ph5", ram_addr, 13'h1005);
    tick_wait(3'd6);
    chk("rd_wait_ph6", wait_n, 0);
    chk("rd_addr_ph6", ram_addr, 13'h0123);
    tick_wait(3'd7);
    chk("rd_wait_ph7", wait_n, 1);
    chk("rd_data", cpu_rdata, 8'h5A);
    chk("rd_addr_ph7", ram_addr, 13'h1007);
    chk("rd_no_we", we_cyc - we0, 0);
    @(negedge clk);
    release_bus();
    repeat (2) @(negedge clk);
    exp_rd = 8'h5A;

`ifndef PSYCHIC5_VRAM_ARB_WRBUF_EN
    tick_wait(3'd0);
    @(negedge clk);
    we0 = we_cyc;
    drive(1'b0, 13'h0040, 8'hA5);
    repeat (3) @(negedge clk);
    chk("wr_wait_low", wait_n, 0);
    tick_wait(3'd6);
    chk("wr_we_ph6", ram_we, 1);
    chk("wr_addr_ph6", ram_addr, 13'h0040);
    chk("wr_di_ph6", ram_di, 8'hA5);
    tick_wait(3'd7);
    chk("wr_we_ph7", ram_we, 0);
    chk("wr_we_len", we_cyc - we0, 4);
    chk("wr_wait_ph7", wait_n, 1);
    @(negedge clk);
    release_bus();
    repeat (2) @(negedge clk);
`else
    tick_wait(3'd0);
    @(negedge clk);
    drive(1'b0, 13'h0002, 8'h11);
    repeat (3) @(negedge clk);
    chk("buf_wr1_nowait", wait_n, 1);
    release_bus();
    repeat (2) @(negedge clk);
    drive(1'b0, 13'h0003, 8'h22);
    repeat (3) @(negedge clk);
    chk("buf_wr2_wait", wait_n, 0);
    tick_wait(3'd6);
    chk("buf_drain1_we", ram_we, 1);
    chk("buf_drain1_addr", ram_addr, 13'h0002);
    chk("buf_drain1_di", ram_di, 8'h11);
    chk("buf_wr2_done", wait_n, 1);
    @(negedge clk);
    release_bus();
    tick_wait(3'd7);
    chk("buf_drain2_we", ram_we, 1);
    chk("buf_drain2_addr", ram_addr, 13'h0003);
    chk("buf_drain2_di", ram_di, 8'h22);
    cpu_access(1'b1, 13'h0003, 8'h00, q, ok);
    chk("buf_rd_ok", ok, 1);
    chk("buf_rd_data", q, 8'h22);
    exp_rd = 8'h22;
`endif

    // request withdrawn while waiting for the slot
    tick_wait(3'd0);
    @(negedge clk);
    we0 = we_cyc;
`ifndef PSYCHIC5_VRAM_ARB_WRBUF_EN
    drive(1'b0, 13'h0123, 8'hEE);
`else
    drive(1'b1, 13'h0123, 8'h00);
`endif
    repeat (6) @(negedge clk);
    release_bus();
    tick_wait(3'd6);
    chk("abort_addr_ph6", ram_addr, 13'h1006);
    chk("abort_we_ph6", ram_we, 0);
    tick_wait(3'd7);
    chk("abort_no_we", we_cyc - we0, 0);
    chk("abort_rdata", cpu_rdata, exp_rd);
    chk("abort_wait_n", wait_n, 1);

    for (int k = 0; k < 8; k++) begin
      cpu_access(acc_tab[k].rd, acc_tab[k].addr, acc_tab[k].data, q, ok);
      chk($sformatf("tab%0d_ok", k), ok, 1);
      if (acc_tab[k].rd)
        chk($sformatf("tab%0d_rd", k), q, acc_tab[k].data);
    end

    // video-only fetch sweep, including the CPU-slot phases
    tick_wait(3'd0);
    for (int k = 0; k < 8; k++) begin
      tick_wait(vid_tab[k].ph);
      chk($sformatf("vid_ph%0d", vid_tab[k].ph), vid_data, vid_tab[k].exp);
    end

    // reset lands while a write strobe is on the RAM
    tick_wait(3'd0);
    @(negedge clk);
    drive(1'b0, 13'h0050, 8'h77);
    tick_wait(3'd6);
    chk("rstwr_we_before", ram_we, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rstwr");
    @(negedge clk);
    release_bus();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cpu_access(1'b1, 13'h0000, 8'h00, q, ok);
    chk("post_rst_ok", ok, 1);
    chk("post_rst_rd", q, 8'h99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
